// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select lines of a downstream 4:1 mux.
// Grants are sticky until ready_i is seen or the hold timer expires.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic       ready_i,
  output logic       s0_o,
  output logic       s1_o,
  output logic       valid_o,
  output logic [3:0] grant_o,
  output logic       timeout_o
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       win;
  logic             found;
  logic [1:0]       idx;

  // First set request scanning from ptr upward, wrapping modulo 4.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req_i[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      valid_o   <= 1'b0;
      grant_o   <= '0;
      timeout_o <= 1'b0;
      cnt       <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sel     <= win;
            valid_o <= 1'b1;
            grant_o <= 4'b0001 << win;
            cnt     <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (ready_i || cnt == CNT_W'(MAX_HOLD - 1)) begin
            // Completion outranks expiry when both land on the same edge.
            timeout_o <= ~ready_i;
            valid_o   <= 1'b0;
            grant_o   <= '0;
            ptr       <= sel + 2'd1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s0_o = sel[0];
  assign s1_o = sel[1];

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench: vector table on a default-depth arbiter plus hold-timeout
// sequences on a second instance with a short hold limit.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       rdy = 1'b0;

  logic       a_s0, a_s1, a_v, a_to;
  logic [3:0] a_g;
  logic       b_s0, b_s1, b_v, b_to;
  logic [3:0] b_g;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_i(rdy),
    .s0_o(a_s0), .s1_o(a_s1), .valid_o(a_v), .grant_o(a_g), .timeout_o(a_to)
  );

  mux_sel_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_i(rdy),
    .s0_o(b_s0), .s1_o(b_s1), .valid_o(b_v), .grant_o(b_g), .timeout_o(b_to)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic       v;
    logic [1:0] sel;
    logic [3:0] g;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [3:0] q, input logic y,
                     input logic v, input logic [1:0] s, input logic [3:0] g);
    vec_t e;
    e.rst = r; e.req = q; e.rdy = y; e.v = v; e.sel = s; e.g = g;
    tv.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1 reset
    add(1, 4'b1111, 0, 0, 2'd0, 4'b0000);
    add(1, 4'b1111, 0, 0, 2'd0, 4'b0000);
    // T2 single request, ptr then 3
    add(0, 4'b0100, 1, 1, 2'd2, 4'b0100);
    add(0, 4'b0000, 1, 0, 2'd2, 4'b0000);
    add(0, 4'b1111, 0, 1, 2'd3, 4'b1000);
    add(0, 4'b1111, 1, 0, 2'd3, 4'b0000);
    // T3 round robin with bubbles
    add(0, 4'b1111, 1, 1, 2'd0, 4'b0001);
    add(0, 4'b1111, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b1111, 1, 1, 2'd1, 4'b0010);
    add(0, 4'b1111, 1, 0, 2'd1, 4'b0000);
    add(0, 4'b1111, 1, 1, 2'd2, 4'b0100);
    add(0, 4'b1111, 1, 0, 2'd2, 4'b0000);
    add(0, 4'b1111, 1, 1, 2'd3, 4'b1000);
    add(0, 4'b1111, 1, 0, 2'd3, 4'b0000);
    add(0, 4'b1111, 1, 1, 2'd0, 4'b0001);
    add(0, 4'b1111, 1, 0, 2'd0, 4'b0000);
    // T4 wrap/skip: reach ptr=3, then 0011 grants 0 then 1
    add(0, 4'b0100, 1, 1, 2'd2, 4'b0100);
    add(0, 4'b0100, 1, 0, 2'd2, 4'b0000);
    add(0, 4'b0011, 1, 1, 2'd0, 4'b0001);
    add(0, 4'b0011, 1, 0, 2'd0, 4'b0000);
    add(0, 4'b0011, 1, 1, 2'd1, 4'b0010);
    add(0, 4'b0011, 1, 0, 2'd1, 4'b0000);
    // idle with no request keeps last select
    add(0, 4'b0000, 0, 0, 2'd1, 4'b0000);
    add(0, 4'b0000, 0, 0, 2'd1, 4'b0000);
    // T5 sticky hold while req changes
    add(0, 4'b0100, 0, 1, 2'd2, 4'b0100);
    for (int i = 0; i < 5; i++) add(0, 4'b0001, 0, 1, 2'd2, 4'b0100);
    add(0, 4'b0001, 1, 0, 2'd2, 4'b0000);
    add(0, 4'b0010, 0, 1, 2'd1, 4'b0010);
    // T7 mid-grant reset, ptr back to 0
    add(1, 4'b0010, 0, 0, 2'd0, 4'b0000);
    add(0, 4'b1111, 0, 1, 2'd0, 4'b0001);
    add(0, 4'b1111, 1, 0, 2'd0, 4'b0000);

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; req = tv[i].req; rdy = tv[i].rdy;
      tick();
      chk($sformatf("vec%0d valid", i), a_v, tv[i].v);
      chk($sformatf("vec%0d sel", i), {a_s1, a_s0}, tv[i].sel);
      chk($sformatf("vec%0d grant", i), a_g, tv[i].g);
      chk($sformatf("vec%0d timeout", i), a_to, 0);
    end

    // T6a: MAX_HOLD=4 expiry
    rst = 1; req = 4'b0000; rdy = 0;
    tick();
    chk("t6 reset valid", b_v, 0);
    rst = 0; req = 4'b0001;
    tick();
    chk("t6 grant valid", b_v, 1);
    chk("t6 grant g", b_g, 4'b0001);
    req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6 hold%0d valid", k), b_v, 1);
      chk($sformatf("t6 hold%0d timeout", k), b_to, 0);
    end
    tick();
    chk("t6 expire valid", b_v, 0);
    chk("t6 expire timeout", b_to, 1);
    chk("t6 expire grant", b_g, 4'b0000);
    tick();
    chk("t6 pulse width", b_to, 0);
    // ptr advanced to 1
    req = 4'b1111;
    tick();
    chk("t6 next grant", b_g, 4'b0010);
    chk("t6 next sel", {b_s1, b_s0}, 1);
    // T6b: ready on the 4th held cycle beats expiry
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t6b hold%0d valid", k), b_v, 1);
    end
    rdy = 1;
    tick();
    chk("t6b release valid", b_v, 0);
    chk("t6b no timeout", b_to, 0);
    rdy = 0;
    tick();
    chk("t6b after timeout", b_to, 0);
    chk("t6b regrant", b_g, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
